// File: rtl/sa_inst_issue_queue_pkg.sv
// Shared definitions for the systolic-array instruction issue queue:
// instruction layout, opcodes and issue FSM state encoding.
package sa_inst_issue_queue_pkg;

  localparam int INST_BITS   = 32;
  localparam int OPCODE_FROM = 31;
  localparam int OPCODE_TO   = 28;
  localparam int OPCODE_W    = OPCODE_FROM - OPCODE_TO + 1;
  localparam int ADDRA_FROM  = 27;
  localparam int ADDRA_TO    = 16;
  localparam int ADDRB_FROM  = 15;
  localparam int ADDRB_TO    = 0;

  localparam logic [OPCODE_W-1:0] IDLE_INST = 4'h0;
  localparam logic [OPCODE_W-1:0] AXI_TO_UB = 4'h1;
  localparam logic [OPCODE_W-1:0] UB_TO_AXI = 4'h2;
  localparam logic [OPCODE_W-1:0] MAT_MUL   = 4'h3;
  localparam logic [OPCODE_W-1:0] ACC_TO_UB = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_BITS-1:0] inst);
    return inst[OPCODE_FROM:OPCODE_TO];
  endfunction

endpackage

// File: rtl/sa_inst_issue_queue_if.sv
// Host-side push port, array-side issue handshake and status for the issue queue.
interface sa_inst_issue_queue_if
  import sa_inst_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int INST_W = INST_BITS
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              run;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic              init_inst_pulse;
  logic [INST_W-1:0] instruction;
  logic              idle_flag;
  logic              flag;
  logic [CW-1:0]     count;
  logic              busy;
  logic [15:0]       done_cnt;
  logic              error;

  modport master (
    output run, in_valid, in_inst, idle_flag, flag,
    input  in_ready, init_inst_pulse, instruction, count, busy, done_cnt, error
  );

  modport slave (
    input  run, in_valid, in_inst, idle_flag, flag,
    output in_ready, init_inst_pulse, instruction, count, busy, done_cnt, error
  );
endinterface

// File: rtl/sa_inst_issue_queue_fifo.sv
// Synchronous FIFO holding pending instructions; head is visible combinationally.
// A push while full is dropped even when a pop happens in the same cycle.
module sa_inst_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      else           wr_ptr_r <= wr_ptr_r;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      else           rd_ptr_r <= rd_ptr_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/sa_inst_issue_queue.sv
// Instruction issue queue for the systolic array: buffers host instructions and
// issues them one at a time. Optional watchdog: define SA_INST_QUEUE_TIMEOUT_EN.
module sa_inst_issue_queue
  import sa_inst_issue_queue_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int INST_W         = INST_BITS,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  reset,
  sa_inst_issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_r;
  state_e            next_state_s;
  logic [INST_W-1:0] head_s;
  logic [CW-1:0]     fifo_count_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              latch_s;
  logic              done_inc_s;
  logic              timeout_s;
  logic              pulse_next_s;
  logic              error_next_s;
  logic              pulse_r;
  logic [INST_W-1:0] instruction_r;
  logic [15:0]       done_cnt_r;
  logic              error_r;

  sa_inst_fifo #(.DEPTH(DEPTH), .W(INST_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_valid),
    .pop   (pop_s),
    .wdata (bus.in_inst),
    .rdata (head_s),
    .count (fifo_count_s),
    .full  (full_s),
    .empty (empty_s)
  );

`ifdef SA_INST_QUEUE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_r;

  // Watchdog restarts on every state change and counts while a transaction is open.
  always_ff @(posedge clk) begin
    if (reset)                                          wd_cnt_r <= {WD_W{1'b0}};
    else if (next_state_s != state_r)                   wd_cnt_r <= {WD_W{1'b0}};
    else if ((state_r == S_ISSUE) || (state_r == S_WAIT)) wd_cnt_r <= wd_cnt_r + WD_W'(1);
    else                                                wd_cnt_r <= wd_cnt_r;
  end

  assign timeout_s = ((state_r == S_ISSUE) || (state_r == S_WAIT)) &&
                     (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; a normal exit takes priority over a watchdog expiry.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    latch_s      = 1'b0;
    done_inc_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.run && !empty_s && bus.idle_flag) begin
          next_state_s = S_ISSUE;
          latch_s      = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (opcode_of(instruction_r) == IDLE_INST) begin
          pop_s        = 1'b1;
          done_inc_s   = 1'b1;
          next_state_s = S_IDLE;
        end else if (!bus.idle_flag) begin
          pop_s        = 1'b1;
          next_state_s = S_WAIT;
        end else if (timeout_s) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (bus.flag) begin
          done_inc_s   = 1'b1;
          next_state_s = S_IDLE;
        end else if (timeout_s) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_WAIT;
        end
      end
`ifdef SA_INST_QUEUE_TIMEOUT_EN
      S_HALT:  next_state_s = S_HALT;
`else
      S_HALT:  next_state_s = S_IDLE;
`endif
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered.
  always_comb begin
    pulse_next_s = 1'b0;
    error_next_s = 1'b0;
    if (next_state_s == S_ISSUE) pulse_next_s = 1'b1;
    else                         pulse_next_s = 1'b0;
`ifdef SA_INST_QUEUE_TIMEOUT_EN
    if (next_state_s == S_HALT) error_next_s = 1'b1;
    else                        error_next_s = error_r;
`else
    error_next_s = 1'b0;
`endif
  end

  // Output registers; instruction keeps its last issued value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_r       <= 1'b0;
      instruction_r <= {INST_W{1'b0}};
      done_cnt_r    <= 16'd0;
      error_r       <= 1'b0;
    end else begin
      pulse_r <= pulse_next_s;
      error_r <= error_next_s;
      if (latch_s)    instruction_r <= head_s;
      else            instruction_r <= instruction_r;
      if (done_inc_s) done_cnt_r <= done_cnt_r + 16'd1;
      else            done_cnt_r <= done_cnt_r;
    end
  end

  assign bus.in_ready        = !full_s;
  assign bus.count           = fifo_count_s;
  assign bus.init_inst_pulse = pulse_r;
  assign bus.instruction     = instruction_r;
  assign bus.busy            = (state_r != S_IDLE);
  assign bus.done_cnt        = done_cnt_r;
  assign bus.error           = error_r;
endmodule

// File: tb/tb_sa_inst_issue_queue.sv
// Self-checking bench for sa_inst_issue_queue with a behavioural array model
// and an in-order expected-instruction reference; timeout test needs SA_INST_QUEUE_TIMEOUT_EN.
module tb_sa_inst_issue_queue;
  import sa_inst_issue_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int W     = INST_BITS;
  localparam int TO    = 50;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         run_d = 1'b0;
  logic         in_valid_d = 1'b0;
  logic [W-1:0] in_inst_d = '0;
  logic         idle_flag_m = 1'b1;
  logic         flag_m = 1'b0;

  always #5 clk = ~clk;

  sa_inst_issue_queue_if #(.DEPTH(DEPTH), .INST_W(W)) bus ();
  assign bus.run       = run_d;
  assign bus.in_valid  = in_valid_d;
  assign bus.in_inst   = in_inst_d;
  assign bus.idle_flag = idle_flag_m;
  assign bus.flag      = flag_m;

  sa_inst_issue_queue #(.DEPTH(DEPTH), .INST_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int accept_delay = 3;
  int exec_delay   = 10;
  bit never_accept = 1'b0;

  int           acc_cnt = 0, exec_cnt = 0, plen = 0;
  bit           exec_active = 1'b0;
  logic [W-1:0] plen_inst = '0;
  logic [W-1:0] got_inst[$];
  int           got_len[$];
  int           overlap_cyc = 0, unstable_cyc = 0;
  logic [W-1:0] exp_q[$];

  // Array model: accepts after accept_delay pulse cycles, signals done exec_delay later.
  always @(negedge clk) begin
    if (reset) begin
      idle_flag_m = 1'b1; flag_m = 1'b0; acc_cnt = 0; exec_cnt = 0; exec_active = 1'b0; plen = 0;
    end else begin
      if (bus.init_inst_pulse) begin
        if (plen > 0 && bus.instruction !== plen_inst) unstable_cyc++;
        if (plen == 0) plen_inst = bus.instruction;
        plen++;
        if (exec_active) overlap_cyc++;
      end else if (plen > 0) begin
        got_inst.push_back(plen_inst);
        got_len.push_back(plen);
        plen = 0;
      end
      if (flag_m) flag_m = 1'b0;
      if (exec_active) begin
        exec_cnt++;
        if (exec_cnt >= exec_delay) begin
          flag_m = 1'b1; idle_flag_m = 1'b1; exec_active = 1'b0;
        end
      end else if (bus.init_inst_pulse && idle_flag_m && !never_accept &&
                   bus.instruction[OPCODE_FROM:OPCODE_TO] != IDLE_INST) begin
        acc_cnt++;
        if (acc_cnt >= accept_delay) begin
          idle_flag_m = 1'b0; exec_active = 1'b1; exec_cnt = 0; acc_cnt = 0;
        end
      end else begin
        acc_cnt = 0;
      end
    end
  end

  function automatic logic [W-1:0] mk(input logic [3:0] op, input logic [11:0] a, input logic [15:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [W-1:0] rand_inst();
    logic [3:0] ops[4] = '{AXI_TO_UB, UB_TO_AXI, MAT_MUL, ACC_TO_UB};
    return mk(ops[$urandom_range(0, 3)], 12'($urandom), 16'($urandom));
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_inst(input logic [W-1:0] inst);
    in_valid_d = 1'b1;
    in_inst_d  = inst;
    @(negedge clk);
    in_valid_d = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid_d = 1'b1; in_inst_d = rand_inst();
    cycles(2);
    n_checks++; if (bus.init_inst_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", bus.init_inst_pulse); end
    n_checks++; if (bus.instruction !== '0) begin n_fail++; $display("FAIL reset_instruction got %h want 0", bus.instruction); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_done_cnt got %0d want 0", bus.done_cnt); end
    n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", bus.error); end
    reset = 1'b0; in_valid_d = 1'b0;
    cycles(1);
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_push_ignored count got %0d want 0", bus.count); end
  endtask

  task automatic test_single_mat_mul();
    logic [W-1:0] inst;
    logic [15:0] start, delta;
    int base;
    accept_delay = 3; exec_delay = 10; run_d = 1'b1;
    inst = mk(MAT_MUL, 12'h0A5, 16'h1234);
    start = bus.done_cnt; base = got_inst.size();
    push_inst(inst);
    n_checks++; if (bus.count !== 5'd1 || bus.init_inst_pulse !== 1'b0) begin n_fail++; $display("FAIL latency_edge1 count=%0d pulse=%b want 1/0", bus.count, bus.init_inst_pulse); end
    cycles(1);
    n_checks++; if (bus.init_inst_pulse !== 1'b1 || bus.instruction !== inst) begin n_fail++; $display("FAIL latency_edge2 pulse=%b inst=%h want 1/%h", bus.init_inst_pulse, bus.instruction, inst); end
    for (int c = 0; c < 100 && 16'(bus.done_cnt - start) < 16'd1; c++) @(negedge clk);
    delta = bus.done_cnt - start;
    n_checks++; if (delta !== 16'd1) begin n_fail++; $display("FAIL single_done got %0d want 1", delta); end
    n_checks++; if (bus.busy !== 1'b0 || bus.count !== 5'd0) begin n_fail++; $display("FAIL single_idle busy=%b count=%0d want 0/0", bus.busy, bus.count); end
    n_checks++; if (got_inst.size() != base + 1 || got_len[base] != 3) begin n_fail++; $display("FAIL single_pulse_len got %0d pulses want 1 pulse of 3", got_inst.size() - base); end
  endtask

  task automatic test_program();
    logic [15:0] start, delta;
    int base, ov0;
    accept_delay = $urandom_range(1, 4); exec_delay = $urandom_range(1, 12); run_d = 1'b1;
    start = bus.done_cnt; base = got_inst.size(); ov0 = overlap_cyc;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mk(AXI_TO_UB, 12'(i), 16'(16 * i)));
      push_inst(mk(AXI_TO_UB, 12'(i), 16'(16 * i)));
    end
    for (int c = 0; c < 600 && 16'(bus.done_cnt - start) < 16'd16; c++) @(negedge clk);
    cycles(3);
    delta = bus.done_cnt - start;
    n_checks++; if (delta !== 16'd16) begin n_fail++; $display("FAIL program_done got %0d want 16", delta); end
    n_checks++; if (got_inst.size() - base != 16) begin n_fail++; $display("FAIL program_issued got %0d want 16", got_inst.size() - base); end
    for (int i = 0; i < 16 && base + i < got_inst.size(); i++) begin
      n_checks++;
      if (got_inst[base+i] !== exp_q[i] || got_inst[base+i][ADDRA_FROM:ADDRA_TO] !== 12'(i) ||
          got_inst[base+i][ADDRB_FROM:ADDRB_TO] !== 16'(16 * i) || got_len[base+i] != accept_delay) begin
        n_fail++; $display("FAIL program_inst%0d got %h len %0d want %h len %0d", i, got_inst[base+i], got_len[base+i], exp_q[i], accept_delay);
      end
    end
    n_checks++; if (overlap_cyc - ov0 != 0) begin n_fail++; $display("FAIL program_overlap got %0d cycles want 0", overlap_cyc - ov0); end
  endtask

  task automatic test_full_queue();
    logic [W-1:0] inst;
    logic [15:0] start, delta;
    int base;
    accept_delay = $urandom_range(1, 4); exec_delay = $urandom_range(1, 12); run_d = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      inst = rand_inst();
      if (exp_q.size() < DEPTH) exp_q.push_back(inst);
      push_inst(inst);
    end
    n_checks++; if (bus.in_ready !== 1'b0 || bus.count !== 5'd16) begin n_fail++; $display("FAIL full_ready ready=%b count=%0d want 0/16", bus.in_ready, bus.count); end
    push_inst(rand_inst());
    n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_drop count got %0d want 16", bus.count); end
    start = bus.done_cnt; base = got_inst.size();
    run_d = 1'b1;
    for (int c = 0; c < 800 && 16'(bus.done_cnt - start) < 16'd16; c++) @(negedge clk);
    cycles(30);
    delta = bus.done_cnt - start;
    n_checks++; if (delta !== 16'd16) begin n_fail++; $display("FAIL full_done got %0d want 16", delta); end
    n_checks++; if (bus.count !== 5'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL full_drain count=%0d busy=%b want 0/0", bus.count, bus.busy); end
    for (int i = 0; i < 16 && base + i < got_inst.size(); i++) begin
      n_checks++;
      if (got_inst[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL full_inst%0d got %h want %h", i, got_inst[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_idle_inst();
    logic [W-1:0] seq[3];
    logic [15:0] start, delta;
    int base, exp_len;
    accept_delay = $urandom_range(1, 4); exec_delay = $urandom_range(1, 12); run_d = 1'b1;
    seq[0] = mk(MAT_MUL, 12'($urandom), 16'($urandom));
    seq[1] = mk(IDLE_INST, 12'($urandom), 16'($urandom));
    seq[2] = mk(MAT_MUL, 12'($urandom), 16'($urandom));
    start = bus.done_cnt; base = got_inst.size();
    for (int i = 0; i < 3; i++) push_inst(seq[i]);
    for (int c = 0; c < 200 && 16'(bus.done_cnt - start) < 16'd3; c++) @(negedge clk);
    cycles(5);
    delta = bus.done_cnt - start;
    n_checks++; if (delta !== 16'd3) begin n_fail++; $display("FAIL idle_done got %0d want 3", delta); end
    n_checks++; if (got_inst.size() - base != 3) begin n_fail++; $display("FAIL idle_pulses got %0d want 3", got_inst.size() - base); end
    for (int i = 0; i < 3 && base + i < got_inst.size(); i++) begin
      exp_len = (i == 1) ? 1 : accept_delay;
      n_checks++;
      if (got_inst[base+i] !== seq[i] || got_len[base+i] != exp_len) begin
        n_fail++; $display("FAIL idle_seq%0d got %h len %0d want %h len %0d", i, got_inst[base+i], got_len[base+i], seq[i], exp_len);
      end
    end
  endtask

  task automatic test_reset_mid();
    accept_delay = 2; exec_delay = 12; run_d = 1'b1;
    push_inst(mk(MAT_MUL, 12'h001, 16'h0002));
    push_inst(mk(MAT_MUL, 12'h003, 16'h0004));
    for (int c = 0; c < 20 && !exec_active; c++) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre busy got %b want 1", bus.busy); end
    reset = 1'b1;
    cycles(1);
    n_checks++; if (bus.count !== 5'd0 || bus.busy !== 1'b0 || bus.init_inst_pulse !== 1'b0 || bus.done_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midreset count=%0d busy=%b pulse=%b done=%0d want 0/0/0/0", bus.count, bus.busy, bus.init_inst_pulse, bus.done_cnt);
    end
    reset = 1'b0;
    cycles(10);
    n_checks++; if (bus.busy !== 1'b0 || bus.count !== 5'd0) begin n_fail++; $display("FAIL midreset_flush busy=%b count=%0d want 0/0", bus.busy, bus.count); end
  endtask

`ifdef SA_INST_QUEUE_TIMEOUT_EN
  task automatic test_timeout();
    int base;
    never_accept = 1'b1; run_d = 1'b1;
    push_inst(mk(MAT_MUL, 12'h0FF, 16'h00FF));
    for (int c = 0; c < 5 && !bus.init_inst_pulse; c++) @(negedge clk);
    n_checks++; if (bus.init_inst_pulse !== 1'b1) begin n_fail++; $display("FAIL timeout_issue pulse got %b want 1", bus.init_inst_pulse); end
    cycles(TO - 1);
    n_checks++; if (bus.error !== 1'b0 || bus.init_inst_pulse !== 1'b1) begin n_fail++; $display("FAIL timeout_early error=%b pulse=%b want 0/1", bus.error, bus.init_inst_pulse); end
    cycles(1);
    n_checks++; if (bus.error !== 1'b1 || bus.init_inst_pulse !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_hit error=%b pulse=%b busy=%b want 1/0/1", bus.error, bus.init_inst_pulse, bus.busy);
    end
    never_accept = 1'b0; base = got_inst.size();
    push_inst(mk(MAT_MUL, 12'h011, 16'h0022));
    cycles(20);
    n_checks++; if (bus.count !== 5'd2 || got_inst.size() != base + 1 || bus.init_inst_pulse !== 1'b0) begin
      n_fail++; $display("FAIL timeout_halt count=%0d pulses=%0d want 2/1", bus.count, got_inst.size() - base);
    end
    reset = 1'b1; cycles(2); reset = 1'b0; cycles(1);
    n_checks++; if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_clear error=%b busy=%b want 0/0", bus.error, bus.busy); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin
    test_reset();
    test_single_mat_mul();
    test_program();
    test_full_queue();
    test_idle_inst();
    test_reset_mid();
`ifdef SA_INST_QUEUE_TIMEOUT_EN
    test_timeout();
`else
    n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL error_tied got %b want 0", bus.error); end
`endif
    n_checks++; if (unstable_cyc != 0) begin n_fail++; $display("FAIL instruction_stable got %0d changes want 0", unstable_cyc); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
